// File: rtl/seg_arbiter.sv
// ---------------------------------------------------------------------------
// seg_arbiter
//
// Shares a 4-digit multiplexed 7-segment display between two requesters:
// a hex score readout and a raw-segment message (e.g. a game banner).
// The block generates its own digit refresh timing, arbitrates only at
// frame boundaries and snapshots the winning source's data once per frame,
// so a frame is never a mix of old and new digits. The score can blink.
//
// Ports
//   segclk       display clock, every register is on its rising edge
//   clr          synchronous active-high reset
//   score_req    score source wants the display
//   score_val    four hex digits, [15:12] is the leftmost
//   blink_en     blink the score while it owns the display
//   msg_req      message source wants the display (has priority)
//   msg_chars    four active-low raw segment codes, [27:21] is the leftmost,
//                bit 0 of each code is segment a, bit 6 is segment g
//   score_grant  score currently owns the display
//   msg_grant    message currently owns the display
//   frame_done   one-cycle pulse on the last cycle of each 4-digit frame
//   seg          segment cathodes, active-low, registered
//   an           digit anodes, active-low, registered, an[3] is leftmost
// ---------------------------------------------------------------------------
module seg_arbiter #(
    parameter int REFRESH_DIV  = 4,   // cycles each digit is lit, >= 2
    parameter int HOLD_FRAMES  = 8,   // minimum frames a granted message stays
    parameter int BLINK_FRAMES = 4    // frames per blink half-period, power of two
) (
    input  logic        segclk,
    input  logic        clr,
    input  logic        score_req,
    input  logic [15:0] score_val,
    input  logic        blink_en,
    input  logic        msg_req,
    input  logic [27:0] msg_chars,
    output logic        score_grant,
    output logic        msg_grant,
    output logic        frame_done,
    output logic [6:0]  seg,
    output logic [3:0]  an
);

    localparam int DIV_W     = $clog2(REFRESH_DIV);
    localparam int HOLD_W    = $clog2(HOLD_FRAMES + 1);
    localparam int BLINK_BIT = $clog2(BLINK_FRAMES);
    localparam int BLK_W     = BLINK_BIT + 1;

    localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(REFRESH_DIV - 1);
    localparam logic [HOLD_W-1:0] HOLD_MAX  = HOLD_W'(HOLD_FRAMES);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_FRAMES - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SCORE = 2'd1,
        ST_MSG   = 2'd2
    } state_t;

    state_t            state_q,     state_d;
    logic [DIV_W-1:0]  div_q,       div_d;
    logic [1:0]        digit_q,     digit_d;     // 0 = leftmost digit
    logic [HOLD_W-1:0] hold_q,      hold_d;
    logic [BLK_W-1:0]  blink_cnt_q, blink_cnt_d;
    logic [15:0]       score_lat_q, score_lat_d;
    logic [27:0]       msg_lat_q,   msg_lat_d;
    logic              blink_lat_q, blink_lat_d;
    logic [6:0]        seg_q,       seg_d;
    logic [3:0]        an_q,        an_d;

    logic tick;
    logic frame_end;
    logic blank;

    // Per-digit views of the frame snapshot, index 0 = leftmost digit.
    logic [6:0] msg_code  [4];
    logic [3:0] score_nib [4];

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_digit
            assign msg_code[gi]  = msg_lat_d[27 - 7*gi -: 7];
            assign score_nib[gi] = score_lat_d[15 - 4*gi -: 4];
        end
    endgenerate

    function automatic logic [6:0] hex7(input logic [3:0] nib);
        logic [6:0] s;
        case (nib)
            4'h0: s = 7'b1000000;
            4'h1: s = 7'b1111001;
            4'h2: s = 7'b0100100;
            4'h3: s = 7'b0110000;
            4'h4: s = 7'b0011001;
            4'h5: s = 7'b0010010;
            4'h6: s = 7'b0000010;
            4'h7: s = 7'b1111000;
            4'h8: s = 7'b0000000;
            4'h9: s = 7'b0010000;
            4'hA: s = 7'b0001000;
            4'hB: s = 7'b0000011;
            4'hC: s = 7'b1000110;
            4'hD: s = 7'b0100001;
            4'hE: s = 7'b0000110;
            default: s = 7'b0001110;
        endcase
        return s;
    endfunction

    assign tick      = (div_q == DIV_LAST);
    assign frame_end = tick && (digit_q == 2'd3);

    always_comb begin
        div_d       = tick ? '0 : div_q + 1'b1;
        digit_d     = tick ? digit_q + 2'd1 : digit_q;   // 3 wraps to 0
        state_d     = state_q;
        hold_d      = hold_q;
        blink_cnt_d = blink_cnt_q;
        score_lat_d = score_lat_q;
        msg_lat_d   = msg_lat_q;
        blink_lat_d = blink_lat_q;

        if (frame_end) begin
            blink_cnt_d = blink_cnt_q + 1'b1;
            score_lat_d = score_val;
            msg_lat_d   = msg_chars;
            blink_lat_d = blink_en;   // sampled per frame so a frame is never half blanked

            case (state_q)
                ST_IDLE, ST_SCORE: begin
                    if (msg_req) begin
                        state_d = ST_MSG;
                        hold_d  = '0;
                    end else if (state_q == ST_IDLE && score_req) begin
                        state_d = ST_SCORE;
                    end else if (state_q == ST_SCORE && !score_req) begin
                        state_d = ST_IDLE;
                    end
                end
                ST_MSG: begin
                    if (hold_q != HOLD_MAX) begin
                        hold_d = hold_q + 1'b1;
                    end
                    // hold_q counts message frames already finished before this one
                    if (!msg_req && hold_q >= HOLD_LAST) begin
                        state_d = score_req ? ST_SCORE : ST_IDLE;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end

        // Outputs are derived from next-state values so the registered pins
        // line up with the digit/owner that the registers are about to hold.
        blank = (state_d == ST_IDLE) ||
                (state_d == ST_SCORE && blink_lat_d && blink_cnt_d[BLINK_BIT]);
        if (blank) begin
            an_d  = 4'b1111;
            seg_d = 7'b1111111;
        end else begin
            an_d  = ~(4'b1000 >> digit_d);
            seg_d = (state_d == ST_MSG) ? msg_code[digit_d] : hex7(score_nib[digit_d]);
        end
    end

    always_ff @(posedge segclk) begin
        if (clr) begin
            state_q     <= ST_IDLE;
            div_q       <= '0;
            digit_q     <= 2'd0;
            hold_q      <= '0;
            blink_cnt_q <= '0;
            score_lat_q <= '0;
            msg_lat_q   <= '0;
            blink_lat_q <= 1'b0;
            seg_q       <= 7'b1111111;
            an_q        <= 4'b1111;
        end else begin
            state_q     <= state_d;
            div_q       <= div_d;
            digit_q     <= digit_d;
            hold_q      <= hold_d;
            blink_cnt_q <= blink_cnt_d;
            score_lat_q <= score_lat_d;
            msg_lat_q   <= msg_lat_d;
            blink_lat_q <= blink_lat_d;
            seg_q       <= seg_d;
            an_q        <= an_d;
        end
    end

    assign seg         = seg_q;
    assign an          = an_q;
    assign score_grant = (state_q == ST_SCORE);
    assign msg_grant   = (state_q == ST_MSG);
    assign frame_done  = frame_end;

endmodule

// File: tb/tb_seg_arbiter.sv
// ---------------------------------------------------------------------------
// tb_seg_arbiter
//
// A frame-level reference model decides the owner of each frame from the
// arbitration rules, snapshots the data and pushes the 16 expected output
// cycles of that frame into a queue. A monitor pops one entry per cycle on
// the falling edge and compares it with the pins.
// ---------------------------------------------------------------------------
module tb_seg_arbiter;

    localparam int R  = 4;
    localparam int H  = 8;
    localparam int B  = 4;
    localparam int FL = 4 * R;

    logic        segclk = 1'b0;
    logic        clr;
    logic        score_req;
    logic [15:0] score_val;
    logic        blink_en;
    logic        msg_req;
    logic [27:0] msg_chars;
    logic        score_grant;
    logic        msg_grant;
    logic        frame_done;
    logic [6:0]  seg;
    logic [3:0]  an;

    seg_arbiter #(
        .REFRESH_DIV (R),
        .HOLD_FRAMES (H),
        .BLINK_FRAMES(B)
    ) dut (
        .segclk     (segclk),
        .clr        (clr),
        .score_req  (score_req),
        .score_val  (score_val),
        .blink_en   (blink_en),
        .msg_req    (msg_req),
        .msg_chars  (msg_chars),
        .score_grant(score_grant),
        .msg_grant  (msg_grant),
        .frame_done (frame_done),
        .seg        (seg),
        .an         (an)
    );

    always #5 segclk = ~segclk;

    typedef struct packed {
        logic       sg;
        logic       mg;
        logic       fd;
        logic [3:0] an;
        logic [6:0] seg;
    } exp_t;

    exp_t exp_q[$];

    int n_checks = 0;
    int n_errors = 0;
    int cycle_no = 0;

    logic [6:0] hex_tab [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
    };

    // ---------------- reference model (frame level) ----------------
    int          m_owner  = 0;   // 0 none, 1 score, 2 message
    int          m_shown  = 0;   // message frames already shown
    int          m_fc     = 0;   // frames since reset
    int          m_pos    = 0;   // cycle position inside current frame
    bit          m_active = 0;
    logic [15:0] m_score  = '0;
    logic [27:0] m_chars  = '0;
    logic        m_blink  = 1'b0;
    int          m_frames = 0;   // frame ends predicted since last reset
    int          d_frames = 0;   // frame_done pulses seen since last reset

    function automatic void push_frame();
        bit blank;
        blank = (m_owner == 0) || (m_owner == 1 && m_blink && ((m_fc / B) % 2 == 1));
        for (int k = 0; k < FL; k++) begin
            exp_t e;
            int d;
            logic [15:0] sh;
            logic [27:0] ch;
            d    = k / R;
            e.sg = (m_owner == 1);
            e.mg = (m_owner == 2);
            e.fd = (k == FL - 1);
            if (blank) begin
                e.an  = 4'b1111;
                e.seg = 7'b1111111;
            end else begin
                e.an = 4'b1111;
                e.an[3 - d] = 1'b0;
                if (m_owner == 2) begin
                    ch    = m_chars >> (7 * (3 - d));
                    e.seg = ch[6:0];
                end else begin
                    sh    = m_score >> (4 * (3 - d));
                    e.seg = hex_tab[sh[3:0]];
                end
            end
            exp_q.push_back(e);
        end
    endfunction

    always @(posedge segclk) begin
        if (clr) begin
            exp_q.delete();
            m_owner  = 0;
            m_shown  = 0;
            m_fc     = 0;
            m_pos    = 0;
            m_blink  = 1'b0;
            m_active = 1;
            m_frames = 0;
            push_frame();
        end else if (m_active) begin
            if (m_pos == FL - 1) begin
                case (m_owner)
                    0: begin
                        if (msg_req) begin m_owner = 2; m_shown = 0; end
                        else if (score_req) m_owner = 1;
                    end
                    1: begin
                        if (msg_req) begin m_owner = 2; m_shown = 0; end
                        else if (!score_req) m_owner = 0;
                    end
                    default: begin
                        m_shown++;
                        if (m_shown >= H && !msg_req) m_owner = score_req ? 1 : 0;
                    end
                endcase
                m_fc++;
                m_frames++;
                m_score = score_val;
                m_chars = msg_chars;
                m_blink = blink_en;
                m_pos   = 0;
                push_frame();
            end else begin
                m_pos++;
            end
        end
    end

    // ---------------- monitor ----------------
    always @(negedge segclk) begin
        cycle_no++;
        if (clr) d_frames = 0;
        else if (frame_done) d_frames++;
        if (m_active) begin
            n_checks++;
            if (score_grant && msg_grant) begin
                n_errors++;
                $display("FAIL excl cyc=%0d both grants high", cycle_no);
            end
            if (exp_q.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL underflow cyc=%0d no expected entry", cycle_no);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                n_checks++;
                if ({score_grant, msg_grant, frame_done} !== {e.sg, e.mg, e.fd}) begin
                    n_errors++;
                    $display("FAIL grant cyc=%0d got sg=%b mg=%b fd=%b want sg=%b mg=%b fd=%b",
                             cycle_no, score_grant, msg_grant, frame_done, e.sg, e.mg, e.fd);
                end
                n_checks++;
                if ({an, seg} !== {e.an, e.seg}) begin
                    n_errors++;
                    $display("FAIL display cyc=%0d got an=%b seg=%b want an=%b seg=%b",
                             cycle_no, an, seg, e.an, e.seg);
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic cyc(input int n);
        repeat (n) @(posedge segclk);
        #1;
    endtask

    task automatic wait_msg_grant();
        int t;
        t = 0;
        while (!msg_grant && t < 200) begin
            cyc(1);
            t++;
        end
        n_checks++;
        if (!msg_grant) begin
            n_errors++;
            $display("FAIL msg_wait got msg_grant=%b want 1 within 200 cycles", msg_grant);
        end
    endtask

    task automatic wait_frame_end();
        int t;
        t = 0;
        while (!frame_done && t < 100) begin
            cyc(1);
            t++;
        end
        n_checks++;
        if (!frame_done) begin
            n_errors++;
            $display("FAIL frame_wait got frame_done=%b want 1 within 100 cycles", frame_done);
        end
    endtask

    initial begin
        clr       = 1'b1;
        score_req = 1'b0;
        score_val = 16'h0000;
        blink_en  = 1'b0;
        msg_req   = 1'b0;
        msg_chars = 28'h0;

        // Reset then idle
        cyc(2);
        clr = 1'b0;
        cyc(3 * FL);

        // Score display, then a mid-frame data change
        score_req = 1'b1;
        score_val = 16'h1A8F;
        cyc(3 * FL);
        cyc(5);
        score_val = 16'h0000 | 16'($urandom);
        cyc(2 * FL);

        // Message priority and hold: NERP for one frame of request
        msg_chars = {7'b1001000, 7'b0000110, 7'b1001100, 7'b0001100};
        msg_req   = 1'b1;
        cyc(FL);
        msg_req   = 1'b0;
        cyc(12 * FL);

        // Short request inside one frame is ignored
        wait_frame_end();
        cyc(3);
        msg_req = 1'b1;
        cyc(3);
        msg_req = 1'b0;
        cyc(2 * FL);

        // Back to idle, then simultaneous requests
        score_req = 1'b0;
        cyc(3 * FL);
        score_req = 1'b1;
        msg_req   = 1'b1;
        cyc(3 * FL);
        msg_req   = 1'b0;
        cyc(12 * FL);

        // Blink on, then off
        blink_en = 1'b1;
        cyc(20 * FL);
        blink_en = 1'b0;
        cyc(4 * FL);

        // Reset during the third frame of an active hold
        msg_req = 1'b1;
        wait_msg_grant();
        cyc(2 * FL + 5);
        clr = 1'b1;
        cyc(1);
        clr = 1'b0;
        cyc(5 * FL);
        msg_req = 1'b0;
        cyc(12 * FL);

        // Randomized traffic
        for (int i = 0; i < 150; i++) begin
            score_req = ($urandom_range(0, 3) != 0);
            msg_req   = ($urandom_range(0, 4) == 0);
            blink_en  = $urandom_range(0, 1);
            score_val = 16'($urandom);
            msg_chars = 28'($urandom);
            clr       = ($urandom_range(0, 39) == 0);
            cyc(1);
            clr = 1'b0;
            cyc($urandom_range(1, 40));
        end
        score_req = 1'b0;
        msg_req   = 1'b0;
        cyc(12 * FL);

        // Frame count since the last reset must agree with the model
        n_checks++;
        if (d_frames != m_frames) begin
            n_errors++;
            $display("FAIL frames got %0d frame_done pulses want %0d", d_frames, m_frames);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
